// File: rtl/iwdg_win.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// iwdg_win : windowed independent watchdog with early-warning IRQ, WB slave
// Rev 1.0
// ============================================================================
module iwdg_win #(
  parameter int          CNT_W    = 12,
  parameter int          PR_W     = 3,
  parameter int          DAT_W    = 16,
  parameter logic [31:0] BASE_ADR = 32'h0100_0000
) (
  input  logic             clk_m2s,
  input  logic             rst_m2s,
  input  logic [DAT_W-1:0] dat_m2s,
  input  logic [31:0]      adr_m2s,
  input  logic             cyc_m2s,
  input  logic             stb_m2s,
  input  logic             we_m2s,
  output logic [DAT_W-1:0] dat_s2m,
  output logic             ack_s2m,
  output logic             rst_iwdg,
  output logic             ewi_irq
);

  // Wide enough for the largest divider minus one (4 << (2^PR_W - 1)) - 1.
  localparam int          C_PSC_W       = (1 << PR_W) + 1;
  localparam logic [15:0] C_KEY_START   = 16'hCCCC;
  localparam logic [15:0] C_KEY_REFRESH = 16'hAAAA;
  localparam logic [15:0] C_KEY_UNLOCK  = 16'h5555;

  logic [CNT_W-1:0]   cnt_q, cnt_d, rlr_q, rlr_d, winr_q, winr_d, ewt_q, ewt_d;
  logic [C_PSC_W-1:0] psc_q, psc_d;
  logic [PR_W-1:0]    pr_q, pr_d;
  logic               run_q, run_d, unlk_q, unlk_d, ewif_q, ewif_d, ewie_q, ewie_d;
  logic               ack_q, ack_d, rst_iwdg_q, rst_iwdg_d;
  logic [DAT_W-1:0]   dat_q, dat_d;

  logic               w_req, w_wr, w_kr_wr, w_tick, w_load;
  logic               w_sel_kr, w_sel_pr, w_sel_rlr, w_sel_sr, w_sel_winr, w_sel_ewcr;
  logic [15:0]        w_key;
  logic [C_PSC_W:0]   w_div;
  logic [C_PSC_W-1:0] w_div_m1;
  logic [CNT_W-1:0]   w_cnt_dec;
  logic [DAT_W-1:0]   w_rdata;

  always_comb begin
    w_req      = cyc_m2s & stb_m2s & ~ack_q;
    w_wr       = w_req & we_m2s;
    w_key      = dat_m2s[15:0];
    w_sel_kr   = (adr_m2s == BASE_ADR);
    w_sel_pr   = (adr_m2s == BASE_ADR + 32'h4);
    w_sel_rlr  = (adr_m2s == BASE_ADR + 32'h8);
    w_sel_sr   = (adr_m2s == BASE_ADR + 32'hC);
    w_sel_winr = (adr_m2s == BASE_ADR + 32'h10);
    w_sel_ewcr = (adr_m2s == BASE_ADR + 32'h14);
    w_kr_wr    = w_wr & w_sel_kr;
    w_div      = (C_PSC_W+1)'(4) << pr_q;
    w_div_m1   = C_PSC_W'(w_div - (C_PSC_W+1)'(1));
    w_tick     = run_q && (psc_q == '0);
    w_cnt_dec  = cnt_q - CNT_W'(1);
    // A start key only reloads when stopped; a refresh always reloads.
    w_load     = w_kr_wr && ((w_key == C_KEY_REFRESH) || ((w_key == C_KEY_START) && !run_q));
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_pr)   w_rdata = DAT_W'(pr_q);
    if (w_sel_rlr)  w_rdata = DAT_W'(rlr_q);
    if (w_sel_sr)   w_rdata = DAT_W'({ewif_q, unlk_q, run_q});
    if (w_sel_winr) w_rdata = DAT_W'(winr_q);
    if (w_sel_ewcr) begin
      w_rdata[CNT_W-1:0] = ewt_q;
      w_rdata[DAT_W-1]   = ewie_q;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    psc_d      = psc_q;
    rlr_d      = rlr_q;
    winr_d     = winr_q;
    ewt_d      = ewt_q;
    pr_d       = pr_q;
    run_d      = run_q;
    unlk_d     = unlk_q;
    ewif_d     = ewif_q;
    ewie_d     = ewie_q;
    ack_d      = w_req;
    dat_d      = '0;
    rst_iwdg_d = 1'b0;

    if (w_req && !we_m2s) dat_d = w_rdata;
    if (w_wr && w_sel_sr && dat_m2s[2]) ewif_d = 1'b0;

    // A reload on a tick edge pre-empts that tick entirely.
    if (w_load) begin
      cnt_d = rlr_q;
      psc_d = w_div_m1;
      if (w_key == C_KEY_START) run_d = 1'b1;
      if ((w_key == C_KEY_REFRESH) && run_q && (cnt_q > winr_q)) rst_iwdg_d = 1'b1;
    end else if (w_tick) begin
      psc_d = w_div_m1;
      if (cnt_q == '0) begin
        cnt_d      = rlr_q;
        rst_iwdg_d = 1'b1;
      end else begin
        cnt_d = w_cnt_dec;
        if (w_cnt_dec == ewt_q) ewif_d = 1'b1;
      end
    end else if (run_q) begin
      psc_d = psc_q - C_PSC_W'(1);
    end

    if (w_kr_wr) unlk_d = (w_key == C_KEY_UNLOCK);
    if (w_wr && unlk_q) begin
      if (w_sel_pr)   pr_d   = dat_m2s[PR_W-1:0];
      if (w_sel_rlr)  rlr_d  = dat_m2s[CNT_W-1:0];
      if (w_sel_winr) winr_d = dat_m2s[CNT_W-1:0];
    end
    if (w_wr && w_sel_ewcr) begin
      ewt_d  = dat_m2s[CNT_W-1:0];
      ewie_d = dat_m2s[DAT_W-1];
    end
  end

  always_ff @(posedge clk_m2s or negedge rst_m2s) begin
    if (!rst_m2s) begin
      cnt_q      <= '1;
      psc_q      <= '0;
      rlr_q      <= '1;
      winr_q     <= '1;
      ewt_q      <= '0;
      pr_q       <= '0;
      run_q      <= 1'b0;
      unlk_q     <= 1'b0;
      ewif_q     <= 1'b0;
      ewie_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      rst_iwdg_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      psc_q      <= psc_d;
      rlr_q      <= rlr_d;
      winr_q     <= winr_d;
      ewt_q      <= ewt_d;
      pr_q       <= pr_d;
      run_q      <= run_d;
      unlk_q     <= unlk_d;
      ewif_q     <= ewif_d;
      ewie_q     <= ewie_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      rst_iwdg_q <= rst_iwdg_d;
    end
  end

  assign dat_s2m  = dat_q;
  assign ack_s2m  = ack_q;
  assign rst_iwdg = rst_iwdg_q;
  assign ewi_irq  = ewif_q & ewie_q;

endmodule
`default_nettype wire
